instruction_decode: RTL and testbench

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/opcode_classify.sv | 30 +++
 rtl/instruction_decode.sv | 146 ++++++++++++++
 tb/tb_instruction_decode.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and
// decode FSM state encoding, reused by fetch, decode and execute.
package cpu_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_ST   = 6'h11;
  localparam logic [5:0] OP_JMP  = 6'h20;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RD_MSB     = 25;
  localparam int RD_LSB     = 21;
  localparam int RS1_MSB    = 20;
  localparam int RS1_LSB    = 16;
  localparam int RS2_MSB    = 15;
  localparam int RS2_LSB    = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 7;
  localparam int JADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } dec_state_e;

  function automatic logic [31:0] sign_extend16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/opcode_classify.sv
// Purely combinational opcode classification: legality plus the two
// opcodes that change decode control flow (jump and halt).
module opcode_classify
  import cpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       legal_o,
  output logic       is_jump_o,
  output logic       is_halt_o
);

  always_comb begin
    legal_o   = 1'b0;
    is_jump_o = 1'b0;
    is_halt_o = 1'b0;
    case (opcode_i)
      OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_ST: legal_o = 1'b1;
      OP_JMP: begin
        legal_o   = 1'b1;
        is_jump_o = 1'b1;
      end
      OP_HALT: begin
        legal_o   = 1'b1;
        is_halt_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_decode.sv
// Instruction decode stage: registers decoded fields with one cycle latency,
// discards wrong-path words after a taken jump and freezes on HALT.
module instruction_decode
  import cpu_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic        stall,
  output logic        dec_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        illegal,
  output logic        branch,
  output logic [7:0]  immediate_address,
  output logic        halted
);

  localparam logic [2:0] SQUASH_INIT = SQUASH_CYCLES[2:0];

  dec_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dec_valid_q, dec_valid_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic        illegal_q, illegal_d;
  logic        branch_q, branch_d;
  logic [7:0]  addr_q, addr_d;
  logic        halted_q, halted_d;

  logic        op_legal;
  logic        op_jump;
  logic        op_halt;

  opcode_classify u_classify (
    .opcode_i  (instruction[OPCODE_MSB:OPCODE_LSB]),
    .legal_o   (op_legal),
    .is_jump_o (op_jump),
    .is_halt_o (op_halt)
  );

  // Everything holds by default; branch is a pulse so it defaults low,
  // which also keeps it low through any stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_valid_d = dec_valid_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    illegal_d   = illegal_q;
    branch_d    = 1'b0;
    addr_d      = addr_q;
    halted_d    = halted_q;

    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          dec_valid_d = instr_valid;
          if (instr_valid) begin
            opcode_d  = instruction[OPCODE_MSB:OPCODE_LSB];
            rd_d      = instruction[RD_MSB:RD_LSB];
            rs1_d     = instruction[RS1_MSB:RS1_LSB];
            rs2_d     = instruction[RS2_MSB:RS2_LSB];
            imm_d     = sign_extend16(instruction[IMM_MSB:IMM_LSB]);
            illegal_d = !op_legal;
            if (op_jump) begin
              branch_d = 1'b1;
              addr_d   = instruction[JADDR_MSB:JADDR_LSB];
              cnt_d    = SQUASH_INIT;
              state_d  = ST_SQUASH;
            end else if (op_halt) begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end
          end
        end
        ST_SQUASH: begin
          dec_valid_d = 1'b0;
          if (instr_valid) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
              state_d = ST_RUN;
            end
          end
        end
        // The HALT word itself was reported once; nothing more is issued.
        ST_HALT: dec_valid_d = 1'b0;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 3'd0;
      dec_valid_q <= 1'b0;
      opcode_q    <= 6'd0;
      rd_q        <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      imm_q       <= 32'd0;
      illegal_q   <= 1'b0;
      branch_q    <= 1'b0;
      addr_q      <= 8'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= dec_valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      illegal_q   <= illegal_d;
      branch_q    <= branch_d;
      addr_q      <= addr_d;
      halted_q    <= halted_d;
    end
  end

  assign dec_valid         = dec_valid_q;
  assign opcode            = opcode_q;
  assign rd                = rd_q;
  assign rs1               = rs1_q;
  assign rs2               = rs2_q;
  assign imm               = imm_q;
  assign illegal           = illegal_q;
  assign branch            = branch_q;
  assign immediate_address = addr_q;
  assign halted            = halted_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: a table of directed vectors
// followed by hand-written stall, reset and halt sequences.
module tb_instruction_decode;

  typedef struct packed {
    logic        dv;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
    logic        br;
    logic [7:0]  addr;
    logic        halt;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    outs_t       exp;
  } vec_t;

  localparam logic [31:0] W_ADD = 32'h0422_1800;
  localparam logic [31:0] W_JMP = 32'h8000_0017;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        dec_valid;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        illegal;
  logic        branch;
  logic [7:0]  immediate_address;
  logic        halted;

  int checks = 0;
  int passes = 0;
  vec_t vecs[14];

  instruction_decode #(.SQUASH_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .instruction       (instruction),
    .instr_valid       (instr_valid),
    .stall             (stall),
    .dec_valid         (dec_valid),
    .opcode            (opcode),
    .rd                (rd),
    .rs1               (rs1),
    .rs2               (rs2),
    .imm               (imm),
    .illegal           (illegal),
    .branch            (branch),
    .immediate_address (immediate_address),
    .halted            (halted)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic dv, input logic [5:0] op,
                               input logic [4:0] r_d, input logic [4:0] r_s1,
                               input logic [4:0] r_s2, input logic [31:0] im,
                               input logic ill, input logic br,
                               input logic [7:0] ad, input logic hl);
    return {dv, op, r_d, r_s1, r_s2, im, ill, br, ad, hl};
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic applyStimulus(input logic [31:0] w, input logic v, input logic s);
    instruction = w;
    instr_valid = v;
    stall       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {dec_valid, opcode, rd, rs1, rs2, imm, illegal, branch,
           immediate_address, halted};
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else
      passes++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    outs_t zero;
    outs_t addOut;
    zero   = mk(0, 6'h00, 0, 0, 0, 32'h0, 0, 0, 8'h00, 0);
    addOut = mk(1, 6'h01, 1, 2, 3, 32'h0000_1800, 0, 0, 8'h00, 0);

    vecs[0]  = '{32'h2085_FFFC, 1, 0, mk(1, 6'h08, 4, 5, 31, 32'hFFFF_FFFC, 0, 0, 8'h00, 0)};
    vecs[1]  = '{W_ADD,         1, 0, addOut};
    vecs[2]  = '{32'h2000_7FFF, 0, 0, mk(0, 6'h01, 1, 2, 3, 32'h0000_1800, 0, 0, 8'h00, 0)};
    vecs[3]  = '{32'hF800_0000, 1, 0, mk(1, 6'h3E, 0, 0, 0, 32'h0, 1, 0, 8'h00, 0)};
    vecs[4]  = '{W_ADD,         1, 1, mk(1, 6'h3E, 0, 0, 0, 32'h0, 1, 0, 8'h00, 0)};
    vecs[5]  = '{32'h0800_8000, 1, 0, mk(1, 6'h02, 0, 0, 16, 32'hFFFF_8000, 0, 0, 8'h00, 0)};
    vecs[6]  = '{32'h2000_7FFF, 1, 0, mk(1, 6'h08, 0, 0, 15, 32'h0000_7FFF, 0, 0, 8'h00, 0)};
    vecs[7]  = '{32'h4000_0001, 1, 0, mk(1, 6'h10, 0, 0, 0, 32'h0000_0001, 0, 0, 8'h00, 0)};
    vecs[8]  = '{32'h4400_0000, 1, 0, mk(1, 6'h11, 0, 0, 0, 32'h0, 0, 0, 8'h00, 0)};
    vecs[9]  = '{32'h0000_0000, 1, 0, mk(1, 6'h00, 0, 0, 0, 32'h0, 0, 0, 8'h00, 0)};
    vecs[10] = '{W_JMP,         1, 0, mk(1, 6'h20, 0, 0, 0, 32'h17, 0, 1, 8'h17, 0)};
    vecs[11] = '{W_ADD,         1, 0, mk(0, 6'h20, 0, 0, 0, 32'h17, 0, 0, 8'h17, 0)};
    vecs[12] = '{32'h8000_00AA, 1, 0, mk(0, 6'h20, 0, 0, 0, 32'h17, 0, 0, 8'h17, 0)};
    vecs[13] = '{W_ADD,         1, 0, mk(1, 6'h01, 1, 2, 3, 32'h1800, 0, 0, 8'h17, 0)};

    // Power-on reset, released mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", zero);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].valid, vecs[i].stall);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // JMP held off by stall: no branch until the stall drops, then exactly one pulse.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h8000_0042, 1, 1);
      checkOutput($sformatf("jmp_stalled%0d", i), mk(1, 6'h01, 1, 2, 3, 32'h1800, 0, 0, 8'h17, 0));
    end
    applyStimulus(32'h8000_0042, 1, 0);
    checkOutput("jmp_after_stall", mk(1, 6'h20, 0, 0, 0, 32'h42, 0, 1, 8'h42, 0));
    applyStimulus(W_ADD, 1, 1);
    checkOutput("branch_low_in_stall", mk(1, 6'h20, 0, 0, 0, 32'h42, 0, 0, 8'h42, 0));
    applyStimulus(W_ADD, 1, 0);
    checkOutput("squash1", mk(0, 6'h20, 0, 0, 0, 32'h42, 0, 0, 8'h42, 0));
    applyStimulus(W_ADD, 1, 0);
    checkOutput("squash2", mk(0, 6'h20, 0, 0, 0, 32'h42, 0, 0, 8'h42, 0));
    applyStimulus(W_ADD, 1, 0);
    checkOutput("post_squash", mk(1, 6'h01, 1, 2, 3, 32'h1800, 0, 0, 8'h42, 0));

    // Asynchronous reset in the middle of a squash window.
    applyStimulus(W_JMP, 1, 0);
    checkOutput("jmp_before_reset", mk(1, 6'h20, 0, 0, 0, 32'h17, 0, 1, 8'h17, 0));
    applyStimulus(W_ADD, 1, 0);
    checkOutput("squash_before_reset", mk(0, 6'h20, 0, 0, 0, 32'h17, 0, 0, 8'h17, 0));
    #2 rst = 1'b0;
    #1 checkOutput("async_reset", zero);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkOutput("release_no_change", zero);
    applyStimulus(W_ADD, 1, 0);
    checkOutput("add_after_reset", addOut);
    applyStimulus(W_ADD, 1, 0);
    checkOutput("add_after_reset2", addOut);

    // HALT freezes decode until a reset pulse.
    applyStimulus(32'hFC00_0000, 1, 0);
    checkOutput("halt", mk(1, 6'h3F, 0, 0, 0, 32'h0, 0, 0, 8'h00, 1));
    applyStimulus(W_JMP, 1, 0);
    checkOutput("halt_ignores_jmp", mk(0, 6'h3F, 0, 0, 0, 32'h0, 0, 0, 8'h00, 1));
    applyStimulus(W_ADD, 1, 0);
    checkOutput("halt_ignores_add", mk(0, 6'h3F, 0, 0, 0, 32'h0, 0, 0, 8'h00, 1));
    #2 rst = 1'b0;
    #1 checkOutput("halt_reset", zero);
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(W_ADD, 1, 0);
    checkOutput("add_after_halt", addOut);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
